// File: rtl/epu_buf_slave.sv
// AXI slave word buffer on interconnect port S6: DMA bursts land in a local RAM
// that the EPU core reads through a registered local port and AXI can read back.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module epu_buf_slave #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`AXI_IDS_BITS-1:0]   AWID_S6,
    input  logic [31:0]                AWADDR_S6,
    input  logic [`AXI_LEN_BITS-1:0]   AWLEN_S6,
    input  logic [2:0]                 AWSIZE_S6,
    input  logic [1:0]                 AWBURST_S6,
    input  logic                       AWVALID_S6,
    output logic                       AWREADY_S6,
    input  logic [31:0]                WDATA_S6,
    input  logic [3:0]                 WSTRB_S6,
    input  logic                       WLAST_S6,
    input  logic                       WVALID_S6,
    output logic                       WREADY_S6,
    output logic [`AXI_IDS_BITS-1:0]   BID_S6,
    output logic [1:0]                 BRESP_S6,
    output logic                       BVALID_S6,
    input  logic                       BREADY_S6,
    input  logic [`AXI_IDS_BITS-1:0]   ARID_S6,
    input  logic [31:0]                ARADDR_S6,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_S6,
    input  logic [2:0]                 ARSIZE_S6,
    input  logic [1:0]                 ARBURST_S6,
    input  logic                       ARVALID_S6,
    output logic                       ARREADY_S6,
    output logic [`AXI_IDS_BITS-1:0]   RID_S6,
    output logic [31:0]                RDATA_S6,
    output logic [1:0]                 RRESP_S6,
    output logic                       RLAST_S6,
    output logic                       RVALID_S6,
    input  logic                       RREADY_S6,
    input  logic [$clog2(DEPTH)-1:0]   epu_raddr,
    output logic [31:0]                epu_rdata,
    input  logic                       buf_clear,
    output logic [15:0]                wr_word_cnt,
    output logic                       buf_wr_done
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = `AXI_LEN_BITS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0]      mem [DEPTH];
    w_state_t         w_state, w_state_nx;
    r_state_t         r_state, r_state_nx;
    logic [IDX_W-1:0] w_idx, r_idx, ar_idx, aw_idx;
    logic [LEN_W-1:0] w_len, w_cnt, r_len, r_cnt;
    logic             w_over;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             unused_bits;

    assign aw_hs  = AWVALID_S6 & AWREADY_S6;
    assign w_hs   = WVALID_S6 & WREADY_S6;
    assign b_hs   = BVALID_S6 & BREADY_S6;
    assign ar_hs  = ARVALID_S6 & ARREADY_S6;
    assign r_hs   = RVALID_S6 & RREADY_S6;
    assign aw_idx = AWADDR_S6[IDX_W+1:2];
    assign ar_idx = ARADDR_S6[IDX_W+1:2];
    assign unused_bits = ^{AWSIZE_S6, AWBURST_S6, ARSIZE_S6, ARBURST_S6,
                           AWADDR_S6[31:IDX_W+2], AWADDR_S6[1:0],
                           ARADDR_S6[31:IDX_W+2], ARADDR_S6[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        r_state_nx = r_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
            W_DATA:  if (w_hs && WLAST_S6) w_state_nx = W_RESP;
            W_RESP:  if (b_hs) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
            R_DATA:  if (r_hs && RLAST_S6) r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Write channel; w_over latches a burst that ran past its LEN without WLAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AWREADY_S6  <= 1'b1;
            WREADY_S6   <= 1'b0;
            BVALID_S6   <= 1'b0;
            BID_S6      <= '0;
            BRESP_S6    <= RESP_OKAY;
            buf_wr_done <= 1'b0;
            w_idx       <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_over      <= 1'b0;
        end else begin
            AWREADY_S6  <= (w_state_nx == W_IDLE);
            WREADY_S6   <= (w_state_nx == W_DATA);
            BVALID_S6   <= (w_state_nx == W_RESP);
            buf_wr_done <= w_hs & WLAST_S6;
            if (aw_hs) begin
                BID_S6 <= AWID_S6;
                w_idx  <= aw_idx;
                w_len  <= AWLEN_S6;
                w_cnt  <= '0;
                w_over <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= w_idx + IDX_W'(1);
                w_cnt <= w_cnt + LEN_W'(1);
                if (w_cnt == w_len && !WLAST_S6) w_over <= 1'b1;
                if (WLAST_S6) BRESP_S6 <= (w_cnt == w_len && !w_over) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (WSTRB_S6[i]) mem[w_idx][8*i +: 8] <= WDATA_S6[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              wr_word_cnt <= '0;
        else if (buf_clear)                    wr_word_cnt <= '0;
        else if (w_hs && wr_word_cnt != '1)    wr_word_cnt <= wr_word_cnt + 16'(1);
    end

    // Read channel and local port; RAM reads see pre-write data on a same-cycle hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ARREADY_S6 <= 1'b1;
            RVALID_S6  <= 1'b0;
            RLAST_S6   <= 1'b0;
            RID_S6     <= '0;
            RRESP_S6   <= RESP_OKAY;
            RDATA_S6   <= '0;
            epu_rdata  <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            ARREADY_S6 <= (r_state_nx == R_IDLE);
            RVALID_S6  <= (r_state_nx == R_DATA);
            RRESP_S6   <= RESP_OKAY;
            epu_rdata  <= mem[epu_raddr];
            if (ar_hs) begin
                RID_S6   <= ARID_S6;
                r_idx    <= ar_idx;
                r_len    <= ARLEN_S6;
                r_cnt    <= '0;
                RDATA_S6 <= mem[ar_idx];
                RLAST_S6 <= (ARLEN_S6 == '0);
            end else if (r_hs) begin
                if (RLAST_S6) begin
                    RLAST_S6 <= 1'b0;
                end else begin
                    r_idx    <= r_idx + IDX_W'(1);
                    r_cnt    <= r_cnt + LEN_W'(1);
                    RDATA_S6 <= mem[r_idx + IDX_W'(1)];
                    RLAST_S6 <= (r_cnt + LEN_W'(1) == r_len);
                end
            end
        end
    end
endmodule

// File: tb/tb_epu_buf_slave.sv
// Bench for epu_buf_slave: constant table of single-word writes, directed burst
// corner cases, and random bursts checked against a word-array model.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module tb_epu_buf_slave;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned ID_W  = `AXI_IDS_BITS;
    localparam int unsigned LEN_W = `AXI_LEN_BITS;

    logic clk, rst;
    logic [ID_W-1:0] AWID_S6, ARID_S6, BID_S6, RID_S6;
    logic [31:0] AWADDR_S6, ARADDR_S6, WDATA_S6, RDATA_S6, epu_rdata;
    logic [LEN_W-1:0] AWLEN_S6, ARLEN_S6;
    logic [2:0] AWSIZE_S6, ARSIZE_S6;
    logic [1:0] AWBURST_S6, ARBURST_S6, BRESP_S6, RRESP_S6;
    logic AWVALID_S6, AWREADY_S6, WLAST_S6, WVALID_S6, WREADY_S6, BVALID_S6, BREADY_S6;
    logic ARVALID_S6, ARREADY_S6, RLAST_S6, RVALID_S6, RREADY_S6;
    logic [3:0] WSTRB_S6;
    logic [IDX_W-1:0] epu_raddr;
    logic buf_clear, buf_wr_done;
    logic [15:0] wr_word_cnt;

    epu_buf_slave #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .AWID_S6(AWID_S6), .AWADDR_S6(AWADDR_S6), .AWLEN_S6(AWLEN_S6), .AWSIZE_S6(AWSIZE_S6),
        .AWBURST_S6(AWBURST_S6), .AWVALID_S6(AWVALID_S6), .AWREADY_S6(AWREADY_S6),
        .WDATA_S6(WDATA_S6), .WSTRB_S6(WSTRB_S6), .WLAST_S6(WLAST_S6), .WVALID_S6(WVALID_S6),
        .WREADY_S6(WREADY_S6), .BID_S6(BID_S6), .BRESP_S6(BRESP_S6), .BVALID_S6(BVALID_S6),
        .BREADY_S6(BREADY_S6), .ARID_S6(ARID_S6), .ARADDR_S6(ARADDR_S6), .ARLEN_S6(ARLEN_S6),
        .ARSIZE_S6(ARSIZE_S6), .ARBURST_S6(ARBURST_S6), .ARVALID_S6(ARVALID_S6),
        .ARREADY_S6(ARREADY_S6), .RID_S6(RID_S6), .RDATA_S6(RDATA_S6), .RRESP_S6(RRESP_S6),
        .RLAST_S6(RLAST_S6), .RVALID_S6(RVALID_S6), .RREADY_S6(RREADY_S6),
        .epu_raddr(epu_raddr), .epu_rdata(epu_rdata), .buf_clear(buf_clear),
        .wr_word_cnt(wr_word_cnt), .buf_wr_done(buf_wr_done)
    );

    always #5 clk = ~clk;

    int n_vec, n_err, exp_cnt;
    logic [31:0] model [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one write burst of nbeats beats (WLAST on the last); buf_clear rides on beat clr_beat.
    task automatic do_write(input logic [31:0] addr, input int len, input int nbeats,
                            input logic [31:0] dq[$], input logic [3:0] sq[$],
                            input int clr_beat, input logic [ID_W-1:0] id);
        int idx, guard, bdly;
        logic [1:0] exp_resp;
        idx = int'((addr >> 2) % DEPTH);
        @(negedge clk);
        AWID_S6 = id; AWADDR_S6 = addr; AWLEN_S6 = LEN_W'(len); AWVALID_S6 = 1'b1;
        guard = 0;
        while (!AWREADY_S6 && guard < 100) begin @(negedge clk); guard++; end
        if (!AWREADY_S6) begin chk("aw_timeout", 32'd0, 32'd1); AWVALID_S6 = 1'b0; return; end
        @(negedge clk);
        AWVALID_S6 = 1'b0;
        chk("wready_after_aw", 32'(WREADY_S6), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            WVALID_S6 = 1'b1; WDATA_S6 = dq[b]; WSTRB_S6 = sq[b];
            WLAST_S6 = (b == nbeats - 1); buf_clear = (b == clr_beat);
            guard = 0;
            while (!WREADY_S6 && guard < 100) begin @(negedge clk); guard++; end
            if (!WREADY_S6) begin chk("w_timeout", 32'd0, 32'd1); break; end
            for (int k = 0; k < 4; k++)
                if (sq[b][k]) model[idx][8*k +: 8] = dq[b][8*k +: 8];
            exp_cnt = (b == clr_beat) ? 0 : ((exp_cnt == 65535) ? exp_cnt : exp_cnt + 1);
            idx = (idx + 1) % DEPTH;
            @(negedge clk);
            buf_clear = 1'b0;
        end
        WVALID_S6 = 1'b0; WLAST_S6 = 1'b0;
        exp_resp = (nbeats == len + 1) ? 2'b00 : 2'b10;
        chk("bvalid", 32'(BVALID_S6), 32'd1);
        chk("bresp", 32'(BRESP_S6), 32'(exp_resp));
        chk("bid", 32'(BID_S6), 32'(id));
        chk("wr_done_pulse", 32'(buf_wr_done), 32'd1);
        chk("wr_word_cnt", 32'(wr_word_cnt), 32'(exp_cnt));
        bdly = $urandom_range(0, 2);
        for (int d = 0; d < bdly; d++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(BVALID_S6), 32'd1);
        end
        BREADY_S6 = 1'b1;
        @(negedge clk);
        BREADY_S6 = 1'b0;
        chk("bvalid_drop", 32'(BVALID_S6), 32'd0);
        chk("wr_done_clear", 32'(buf_wr_done), 32'd0);
        chk("awready_back", 32'(AWREADY_S6), 32'd1);
    endtask

    // Reads a burst and checks every presented beat; mode 0 ready, 1 toggling, 2 random.
    task automatic do_read(input logic [31:0] addr, input int len, input int mode,
                           input logic [ID_W-1:0] id);
        int idx, beat, cyc, guard;
        logic rr;
        logic [31:0] exp_q[$];
        idx = int'((addr >> 2) % DEPTH);
        for (int b = 0; b <= len; b++) exp_q.push_back(model[(idx + b) % DEPTH]);
        @(negedge clk);
        ARID_S6 = id; ARADDR_S6 = addr; ARLEN_S6 = LEN_W'(len); ARVALID_S6 = 1'b1;
        guard = 0;
        while (!ARREADY_S6 && guard < 100) begin @(negedge clk); guard++; end
        if (!ARREADY_S6) begin chk("ar_timeout", 32'd0, 32'd1); ARVALID_S6 = 1'b0; return; end
        @(negedge clk);
        ARVALID_S6 = 1'b0;
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 400) begin
            chk("rvalid", 32'(RVALID_S6), 32'd1);
            chk("rdata", RDATA_S6, exp_q[beat]);
            chk("rlast", 32'(RLAST_S6), 32'(beat == len));
            chk("rid", 32'(RID_S6), 32'(id));
            chk("rresp", 32'(RRESP_S6), 32'd0);
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            RREADY_S6 = rr;
            @(negedge clk);
            if (rr) beat++;
            cyc++;
        end
        RREADY_S6 = 1'b0;
        if (beat <= len) chk("r_timeout", 32'd0, 32'd1);
        chk("rvalid_drop", 32'(RVALID_S6), 32'd0);
        chk("arready_back", 32'(ARREADY_S6), 32'd1);
    endtask

    task automatic epu_chk(input string name, input int idx, input logic [31:0] exp);
        @(negedge clk);
        epu_raddr = IDX_W'(idx);
        @(negedge clk);
        chk(name, epu_rdata, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[7];
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic [31:0] old_v;
        int g, len, wa;
        n_vec = 0; n_err = 0; exp_cnt = 0;
        tbl[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0014, 32'h1122_3344, 4'hF, 32'h1122_3344};
        tbl[2] = '{32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD};
        tbl[3] = '{32'h0000_0114, 32'h9988_7766, 4'h8, 32'h99BB_33DD};
        tbl[4] = '{32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 32'h1234_5678};
        tbl[5] = '{32'h0000_00FC, 32'hA5A5_A5A5, 4'h2, 32'h1234_A578};
        tbl[6] = '{32'h0000_0008, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};

        clk = 1'b0; rst = 1'b0;
        AWID_S6 = '0; AWADDR_S6 = '0; AWLEN_S6 = '0; AWSIZE_S6 = 3'd2; AWBURST_S6 = 2'd1;
        AWVALID_S6 = 1'b0; WDATA_S6 = '0; WSTRB_S6 = '0; WLAST_S6 = 1'b0; WVALID_S6 = 1'b0;
        BREADY_S6 = 1'b0; ARID_S6 = '0; ARADDR_S6 = '0; ARLEN_S6 = '0; ARSIZE_S6 = 3'd2;
        ARBURST_S6 = 2'd1; ARVALID_S6 = 1'b0; RREADY_S6 = 1'b0; epu_raddr = '0; buf_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(AWREADY_S6), 32'd1);
        chk("rst_arready", 32'(ARREADY_S6), 32'd1);
        chk("rst_wready", 32'(WREADY_S6), 32'd0);
        chk("rst_bvalid", 32'(BVALID_S6), 32'd0);
        chk("rst_rvalid", 32'(RVALID_S6), 32'd0);
        chk("rst_rlast", 32'(RLAST_S6), 32'd0);
        chk("rst_resp", 32'({BRESP_S6, RRESP_S6}), 32'd0);
        chk("rst_ids", 32'({BID_S6, RID_S6}), 32'd0);
        chk("rst_rdata", RDATA_S6, 32'd0);
        chk("rst_epu_rdata", epu_rdata, 32'd0);
        chk("rst_cnt", 32'(wr_word_cnt), 32'd0);
        chk("rst_wr_done", 32'(buf_wr_done), 32'd0);
        rst = 1'b1;

        // Fill the whole buffer so every later read has a defined model value.
        for (int k = 0; k < DEPTH / 16; k++) begin
            dq = {}; sq = {};
            for (int b = 0; b < 16; b++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(32'(k * 64), 15, 16, dq, sq, -1, ID_W'(k));
        end

        for (int i = 0; i < 7; i++) begin
            dq = {tbl[i].wdata}; sq = {tbl[i].strb};
            do_write(tbl[i].addr, 0, 1, dq, sq, -1, ID_W'(i + 8));
            epu_chk("tbl_epu", int'((tbl[i].addr >> 2) % DEPTH), tbl[i].exp);
            do_read(tbl[i].addr, 0, 0, ID_W'(i + 16));
        end

        // Clear, then a wrapping burst 62,63,0,1 read back with a stalling master.
        @(negedge clk); buf_clear = 1'b1;
        @(negedge clk); buf_clear = 1'b0; exp_cnt = 0;
        chk("clear_cnt", 32'(wr_word_cnt), 32'd0);
        dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h0000_00F8, 3, 4, dq, sq, -1, ID_W'(5));
        chk("wrap_cnt4", 32'(wr_word_cnt), 32'd4);
        epu_chk("wrap_w62", 62, 32'd1);
        epu_chk("wrap_w63", 63, 32'd2);
        epu_chk("wrap_w0", 0, 32'd3);
        epu_chk("wrap_w1", 1, 32'd4);
        do_read(32'h0000_00F8, 3, 1, ID_W'(6));

        // Early WLAST on beat 1 of a 4-beat burst.
        dq = {32'hC0DE_0001, 32'hC0DE_0002}; sq = {4'hF, 4'hF};
        do_write(32'h0000_0040, 3, 2, dq, sq, -1, ID_W'(7));
        epu_chk("early_w17", 17, 32'hC0DE_0002);
        do_read(32'h0000_0040, 3, 0, ID_W'(9));

        // Concurrent read 0..7 and write 8..15, with buf_clear on write beat 3.
        dq = {}; sq = {};
        for (int b = 0; b < 8; b++) begin dq.push_back($urandom); sq.push_back(4'hF); end
        fork
            do_read(32'h0000_0000, 7, 0, ID_W'(10));
            do_write(32'h0000_0020, 7, 8, dq, sq, 3, ID_W'(11));
        join
        do_read(32'h0000_0020, 7, 2, ID_W'(12));

        // Local port reads the old word on a same-cycle write.
        old_v = model[20];
        @(negedge clk); epu_raddr = IDX_W'(20);
        dq = {32'h5A5A_0F0F}; sq = {4'hF};
        fork
            do_write(32'h0000_0050, 0, 1, dq, sq, -1, ID_W'(13));
            begin
                g = 0;
                do begin @(negedge clk); #1; g++; end while (!(WVALID_S6 && WREADY_S6) && g < 100);
                @(negedge clk); #1;
                chk("same_cycle_old", epu_rdata, old_v);
                @(negedge clk); #1;
                chk("same_cycle_new", epu_rdata, 32'h5A5A_0F0F);
            end
        join

        // Reset while beat 2 of an 8-beat read is on the bus.
        @(negedge clk);
        ARID_S6 = ID_W'(3); ARADDR_S6 = '0; ARLEN_S6 = LEN_W'(7); ARVALID_S6 = 1'b1;
        @(negedge clk); ARVALID_S6 = 1'b0; RREADY_S6 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat2", RDATA_S6, model[2]);
        rst = 1'b0; #1;
        chk("mid_rvalid", 32'(RVALID_S6), 32'd0);
        chk("mid_rlast", 32'(RLAST_S6), 32'd0);
        chk("mid_rdata", RDATA_S6, 32'd0);
        chk("mid_arready", 32'(ARREADY_S6), 32'd1);
        chk("mid_cnt", 32'(wr_word_cnt), 32'd0);
        RREADY_S6 = 1'b0; exp_cnt = 0;
        @(negedge clk); rst = 1'b1;
        do_read(32'h0000_0000, 7, 0, ID_W'(4));

        // Random bursts against the model.
        for (int it = 0; it < 16; it++) begin
            len = $urandom_range(0, 15);
            dq = {}; sq = {};
            for (int b = 0; b <= len; b++) begin
                dq.push_back($urandom); sq.push_back(4'($urandom));
            end
            do_write($urandom, len, len + 1, dq, sq, -1, ID_W'($urandom));
            do_read($urandom, $urandom_range(0, 15), 2, ID_W'($urandom));
            wa = $urandom_range(0, DEPTH - 1);
            epu_chk("rand_epu", wa, model[wa]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/epu_buf_slave.md
# epu_buf_slave

AXI slave buffer downstream of the DMA engine: receives the DMA's incrementing word bursts (DRAM->EPU transfers) into a local word-addressed buffer and lets the EPU core fetch them through a simple local read port. The same buffer can be read back over AXI for EPU->DRAM transfers. It occupies slave port S6 of the AXI interconnect.

## Interface
- DEPTH, 64: buffer size in 32-bit words; power of two, 4..1024.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- AWID_S6/ARID_S6  in  `AXI_IDS_BITS`  write/read transaction ID.
- AWADDR_S6/ARADDR_S6  in  32  byte address.
- AWLEN_S6/ARLEN_S6  in  `AXI_LEN_BITS`  beats-1.
- AWSIZE_S6/ARSIZE_S6, AWBURST_S6/ARBURST_S6  in  3/2  ignored; every burst is word-sized and incrementing.
- AWVALID_S6/ARVALID_S6  in  1; AWREADY_S6/ARREADY_S6  out  1.
- WDATA_S6  in  32; WSTRB_S6  in  4; WLAST_S6, WVALID_S6  in  1; WREADY_S6  out  1.
- BID_S6  out  `AXI_IDS_BITS`; BRESP_S6  out  2; BVALID_S6  out  1; BREADY_S6  in  1.
- RID_S6  out  `AXI_IDS_BITS`; RDATA_S6  out  32; RRESP_S6  out  2; RLAST_S6, RVALID_S6  out  1; RREADY_S6  in  1.
- epu_raddr  in  log2(DEPTH)  local word index.
- epu_rdata  out  32  registered buffer word.
- buf_clear  in  1  synchronous clear of wr_word_cnt.
- wr_word_cnt  out  16  accepted write beats since clear (saturates at 0xFFFF).
- buf_wr_done  out  1  one-cycle pulse per completed write burst.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses alias modulo DEPTH.
- Each beat increments the index by 1 and wraps from DEPTH-1 to 0.
- Write FSM:
  - W_IDLE: AWREADY=1. An AW handshake captures ID, index and LEN, clears the beat counter, and moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes bytes enabled by WSTRB (bit i -> bits 8i+7:8i), then advances index and beat counter.
  - The WLAST beat moves to W_RESP. BRESP=OKAY if beat counter==LEN at that beat, else SLVERR (2'b10). Data already written is kept.
  - W_RESP: BVALID=1 and BID=captured ID, held until BREADY, then W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. An AR handshake captures ID, index and LEN, registers RDATA<=mem[index], and moves to R_DATA.
  - R_DATA: RVALID=1, RID=captured ID, RRESP=OKAY, RLAST=(beat counter==LEN).
  - A handshake without RLAST loads RDATA<=mem[index+1] and advances.
  - A handshake with RLAST returns to R_IDLE.
  - RDATA and RLAST hold stable while RVALID=1 and RREADY=0.
- Read and write FSMs are independent and may run concurrently. If a read load and a write hit the same word in the same cycle, the read returns the old data.
- Local port: epu_rdata <= mem[epu_raddr] every cycle (1-cycle latency). The same old-data rule applies on a same-cycle write.
- wr_word_cnt increments on every W handshake.
  - buf_clear has priority over an increment in the same cycle (result 0).
  - The counter saturates at 0xFFFF.
- buf_wr_done=1 for exactly the cycle after the WLAST handshake.

## Timing
- Reset (rst=0, asynchronous): both FSMs go to IDLE.
  - Outputs: AWREADY=ARREADY=1, WREADY=BVALID=RVALID=RLAST=0, BRESP=RRESP=0, BID=RID=0, RDATA=epu_rdata=0, wr_word_cnt=0, buf_wr_done=0.
  - Buffer contents are not reset.
  - Reset mid-burst abandons the burst; no B or R response is issued.
- AW handshake at cycle t: WREADY=1 from t+1. The earliest W beat is t+1; W beats offered earlier are not accepted.
- WLAST handshake at t: BVALID and buf_wr_done at t+1; AWREADY returns the cycle after the B handshake.
- AR handshake at t: RVALID with beat 0 at t+1. With RREADY held at 1, beats stream one per cycle, so LEN+1 beats occupy t+1..t+LEN+1.
- After the RLAST handshake at t, ARREADY=1 at t+1.

## Test plan
- Single write then read: AW addr 0x08, LEN 0, W 0xDEADBEEF with WSTRB 0xF -> BRESP OKAY at t+1, buf_wr_done pulse. AR addr 0x08, LEN 0 -> RDATA 0xDEADBEEF, RLAST=1. epu_raddr=2 -> epu_rdata 0xDEADBEEF one cycle later.
- Burst with wrap (DEPTH=64): AW addr 0xF8, LEN 3, data 1,2,3,4 -> words 62,63,0,1 hold 1,2,3,4; wr_word_cnt=4. Read burst from the same address with RREADY toggling 1,0,1,0 -> 1,2,3,4 in order, each held stable while stalled.
- Partial strobe: word 5 = 0x11223344; write 0xAABBCCDD with WSTRB 0x5 -> word reads 0x11BB33DD.
- Early WLAST: AWLEN 3, WLAST on beat 1 -> BRESP=2'b10, two words written, FSM returns to W_IDLE after BREADY.
- Concurrency: read burst of words 0..7 concurrent with write burst to words 8..15 -> both complete with correct data. buf_clear asserted in the same cycle as a W beat -> wr_word_cnt=0.
- Reset mid-burst: assert rst=0 during beat 2 of an 8-beat read -> RVALID=0 immediately; after release, ARREADY=1 and a new burst completes normally.
